otter_ctrl_fsm: RTL and testbench

OTTER_CTRL_FSM -- requirements
Module: otter_ctrl_fsm

---
 rtl/otter_pkg.sv | 27 ++
 rtl/branch_cond_gen.sv | 13 +
 rtl/otter_ctrl_fsm.sv | 109 ++++++++++
 tb/tb_otter_ctrl_fsm.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// otter_pkg: shared state, opcode and PC-select encodings for the OTTER control unit
package otter_pkg;
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [11:0] FUNC12_MRET = 12'h302;
    localparam logic [2:0] PCSEL_NEXT   = 3'd0;
    localparam logic [2:0] PCSEL_JALR   = 3'd1;
    localparam logic [2:0] PCSEL_BRANCH = 3'd2;
    localparam logic [2:0] PCSEL_JAL    = 3'd3;
    localparam logic [2:0] PCSEL_MTVEC  = 3'd4;
    localparam logic [2:0] PCSEL_MEPC   = 3'd5;
endpackage

// File: rtl/branch_cond_gen.sv
// branch_cond_gen: decides whether a conditional branch is taken from func3 and comparator flags
module branch_cond_gen (
    input  logic [2:0] func3,
    input  logic       BR_EQ,
    input  logic       BR_LT,
    input  logic       BR_LTU,
    output logic       taken
);
    // func3[0] inverts the base comparison; func3 01x has no defined branch
    assign taken = (func3[2:1] == 2'b00) ? BR_EQ  ^ func3[0] :
                   (func3[2:1] == 2'b10) ? BR_LT  ^ func3[0] :
                   (func3[2:1] == 2'b11) ? BR_LTU ^ func3[0] : 1'b0;
endmodule

// File: rtl/otter_ctrl_fsm.sv
// otter_ctrl_fsm: multicycle OTTER control FSM sequencing fetch, execute, writeback and trap entry
module otter_ctrl_fsm
    import otter_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IR,
    input  logic        BR_EQ,
    input  logic        BR_LT,
    input  logic        BR_LTU,
    input  logic        INTR,
    input  logic        MIE,
    output logic [2:0]  PC_SOURCE,
    output logic        PC_WRITE,
    output logic        REG_WRITE,
    output logic        MEM_WE2,
    output logic        MEM_RDEN1,
    output logic        MEM_RDEN2,
    output logic        CSR_WE,
    output logic        INT_TAKEN,
    output logic        MRET_EXEC,
    output logic        RST_OUT
);
    state_t state, state_n;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [11:0] func12;
    logic br_taken, trap, unused_ir;
    assign opcode = IR[6:0];
    assign func3 = IR[14:12];
    assign func12 = IR[31:20];
    assign unused_ir = ^{IR[19:15], IR[11:7]};
    assign trap = INTR && MIE;
    branch_cond_gen u_branch_cond_gen (
        .func3 (func3),
        .BR_EQ (BR_EQ),
        .BR_LT (BR_LT),
        .BR_LTU(BR_LTU),
        .taken (br_taken)
    );
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_INIT;
        else     state <= state_n;
    end
    always_comb begin
        state_n = ST_INIT;
        PC_SOURCE = PCSEL_NEXT;
        PC_WRITE = 1'b0;
        REG_WRITE = 1'b0;
        MEM_WE2 = 1'b0;
        MEM_RDEN1 = 1'b0;
        MEM_RDEN2 = 1'b0;
        CSR_WE = 1'b0;
        INT_TAKEN = 1'b0;
        MRET_EXEC = 1'b0;
        RST_OUT = 1'b0;
        case (state)
            ST_INIT: begin
                RST_OUT = 1'b1;
                state_n = ST_FETCH;
            end
            ST_FETCH: begin
                MEM_RDEN1 = 1'b1;
                state_n = ST_EXEC;
            end
            ST_EXEC: begin
                PC_WRITE = 1'b1;
                state_n = trap ? ST_INTR : ST_FETCH;
                case (opcode)
                    OPC_LOAD: begin
                        PC_WRITE = 1'b0;
                        MEM_RDEN2 = 1'b1;
                        state_n = ST_WB;
                    end
                    OPC_STORE: MEM_WE2 = 1'b1;
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: REG_WRITE = 1'b1;
                    OPC_JAL: begin
                        REG_WRITE = 1'b1;
                        PC_SOURCE = PCSEL_JAL;
                    end
                    OPC_JALR: begin
                        REG_WRITE = 1'b1;
                        PC_SOURCE = PCSEL_JALR;
                    end
                    OPC_BRANCH: PC_SOURCE = br_taken ? PCSEL_BRANCH : PCSEL_NEXT;
                    OPC_SYSTEM: begin
                        CSR_WE = (func3 == 3'b001);
                        REG_WRITE = (func3 == 3'b001);
                        MRET_EXEC = (func3 == 3'b000) && (func12 == FUNC12_MRET);
                        PC_SOURCE = MRET_EXEC ? PCSEL_MEPC : PCSEL_NEXT;
                    end
                    default: ;
                endcase
            end
            ST_WB: begin
                REG_WRITE = 1'b1;
                PC_WRITE = 1'b1;
                state_n = trap ? ST_INTR : ST_FETCH;
            end
            ST_INTR: begin
                INT_TAKEN = 1'b1;
                PC_WRITE = 1'b1;
                PC_SOURCE = PCSEL_MTVEC;
                state_n = ST_FETCH;
            end
            default: state_n = ST_INIT;
        endcase
    end
endmodule

// File: tb/tb_otter_ctrl_fsm.sv
// tb_otter_ctrl_fsm: directed scoreboard bench for the OTTER control FSM
module tb_otter_ctrl_fsm;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [31:0] IR = 32'h0;
  logic BR_EQ = 1'b0, BR_LT = 1'b0, BR_LTU = 1'b0, INTR = 1'b0, MIE = 1'b0;
  logic [2:0] PC_SOURCE;
  logic PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2, CSR_WE, INT_TAKEN, MRET_EXEC, RST_OUT;
  int n_pass = 0;
  int n_total = 0;
  logic stim_done = 1'b0;
  typedef struct {
    logic [11:0] exp;
    string nm;
  } exp_t;
  exp_t sb[$];
  localparam logic [11:0] E_INIT  = 12'h800;
  localparam logic [11:0] E_FETCH = 12'h010;
  localparam logic [11:0] E_ALU   = 12'h0C0;
  localparam logic [11:0] E_LOADX = 12'h008;
  localparam logic [11:0] E_WB    = 12'h0C0;
  localparam logic [11:0] E_STORE = 12'h0A0;
  localparam logic [11:0] E_JAL   = 12'h3C0;
  localparam logic [11:0] E_JALR  = 12'h1C0;
  localparam logic [11:0] E_BR_T  = 12'h280;
  localparam logic [11:0] E_BR_N  = 12'h080;
  localparam logic [11:0] E_CSR   = 12'h0C4;
  localparam logic [11:0] E_MRET  = 12'h581;
  localparam logic [11:0] E_INTR  = 12'h482;
  localparam logic [11:0] E_NOP   = 12'h080;
  localparam logic [31:0] I_ADDI  = 32'h00100093;
  localparam logic [31:0] I_LW    = 32'h00002083;
  localparam logic [31:0] I_SW    = 32'h00002023;
  localparam logic [31:0] I_BEQ   = 32'h00000063;
  localparam logic [31:0] I_BNE   = 32'h00001063;
  localparam logic [31:0] I_B010  = 32'h00002063;
  localparam logic [31:0] I_BGE   = 32'h00005063;
  localparam logic [31:0] I_BLTU  = 32'h00006063;
  localparam logic [31:0] I_JAL   = 32'h0000006F;
  localparam logic [31:0] I_JALR  = 32'h00008067;
  localparam logic [31:0] I_CSRRW = 32'h30011073;
  localparam logic [31:0] I_MRET  = 32'h30200073;
  localparam logic [31:0] I_ECALL = 32'h00000073;
  localparam logic [31:0] I_BAD   = 32'h0000007F;
  otter_ctrl_fsm dut (
    .CLK(CLK), .RST(RST), .IR(IR), .BR_EQ(BR_EQ), .BR_LT(BR_LT), .BR_LTU(BR_LTU),
    .INTR(INTR), .MIE(MIE), .PC_SOURCE(PC_SOURCE), .PC_WRITE(PC_WRITE), .REG_WRITE(REG_WRITE),
    .MEM_WE2(MEM_WE2), .MEM_RDEN1(MEM_RDEN1), .MEM_RDEN2(MEM_RDEN2), .CSR_WE(CSR_WE),
    .INT_TAKEN(INT_TAKEN), .MRET_EXEC(MRET_EXEC), .RST_OUT(RST_OUT)
  );
  always #5 CLK = ~CLK;
  task automatic step(input logic rst_v, input logic [31:0] ir_v, input logic [2:0] br_v,
                      input logic intr_v, input logic mie_v, input logic chk,
                      input logic [11:0] exp, input string nm);
    exp_t e;
    @(posedge CLK);
    #1;
    RST = rst_v;
    IR = ir_v;
    {BR_EQ, BR_LT, BR_LTU} = br_v;
    INTR = intr_v;
    MIE = mie_v;
    if (chk) begin
      e.exp = exp;
      e.nm = nm;
      sb.push_back(e);
    end
  endtask
  task automatic instr(input logic [31:0] ir_v, input logic [2:0] br_v, input logic intr_v,
                       input logic mie_v, input logic [11:0] exp, input string nm);
    step(1'b0, ir_v, 3'b000, 1'b0, 1'b0, 1'b1, E_FETCH, {nm, "_fetch"});
    step(1'b0, ir_v, br_v, intr_v, mie_v, 1'b1, exp, {nm, "_exec"});
  endtask
  always @(negedge CLK) begin
    logic [11:0] act;
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      act = {RST_OUT, PC_SOURCE, PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2,
             CSR_WE, INT_TAKEN, MRET_EXEC};
      n_total++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got %03h expected %03h", e.nm, act, e.exp);
    end
  end
  initial begin
    step(1'b1, I_ADDI, 3'b000, 1'b0, 1'b0, 1'b0, 12'h0, "rst");
    step(1'b0, I_ADDI, 3'b000, 1'b0, 1'b0, 1'b1, E_INIT, "init");
    instr(I_ADDI, 3'b000, 1'b0, 1'b0, E_ALU, "addi");
    step(1'b0, I_LW, 3'b000, 1'b1, 1'b1, 1'b1, E_FETCH, "lw_fetch_intr");
    step(1'b0, I_LW, 3'b000, 1'b1, 1'b1, 1'b1, E_LOADX, "lw_exec_intr");
    step(1'b0, I_LW, 3'b000, 1'b1, 1'b1, 1'b1, E_WB, "lw_wb_intr");
    step(1'b0, I_LW, 3'b000, 1'b0, 1'b0, 1'b1, E_INTR, "lw_trap");
    instr(I_SW, 3'b000, 1'b0, 1'b0, E_STORE, "sw");
    instr(I_BGE, 3'b000, 1'b0, 1'b0, E_BR_T, "bge_taken");
    instr(I_BGE, 3'b010, 1'b0, 1'b0, E_BR_N, "bge_not");
    instr(I_B010, 3'b111, 1'b0, 1'b0, E_BR_N, "b010_never");
    instr(I_BLTU, 3'b001, 1'b0, 1'b0, E_BR_T, "bltu_taken");
    instr(I_BEQ, 3'b100, 1'b0, 1'b0, E_BR_T, "beq_taken");
    instr(I_BNE, 3'b100, 1'b0, 1'b0, E_BR_N, "bne_not");
    instr(I_MRET, 3'b000, 1'b1, 1'b0, E_MRET, "mret_mie0");
    instr(I_MRET, 3'b000, 1'b1, 1'b1, E_MRET, "mret_mie1");
    step(1'b0, I_ADDI, 3'b000, 1'b0, 1'b0, 1'b1, E_INTR, "mret_trap");
    instr(I_ADDI, 3'b000, 1'b1, 1'b1, E_ALU, "addi_intr");
    step(1'b0, I_ADDI, 3'b000, 1'b0, 1'b0, 1'b1, E_INTR, "addi_trap");
    instr(I_JAL, 3'b000, 1'b0, 1'b0, E_JAL, "jal");
    instr(I_JALR, 3'b000, 1'b0, 1'b0, E_JALR, "jalr");
    instr(I_CSRRW, 3'b000, 1'b0, 1'b0, E_CSR, "csrrw");
    instr(I_ECALL, 3'b000, 1'b0, 1'b0, E_NOP, "ecall_nop");
    instr(I_BAD, 3'b000, 1'b0, 1'b0, E_NOP, "bad_nop");
    instr(I_LW, 3'b000, 1'b0, 1'b0, E_LOADX, "lw2");
    step(1'b1, I_LW, 3'b000, 1'b0, 1'b0, 1'b1, E_WB, "lw2_wb_rst");
    step(1'b0, I_LW, 3'b000, 1'b0, 1'b0, 1'b1, E_INIT, "lw2_after_rst");
    instr(I_ADDI, 3'b000, 1'b0, 1'b0, E_ALU, "addi_final");
    @(posedge CLK);
    stim_done = 1'b1;
  end
  initial begin
    fork
      wait (stim_done && sb.size() == 0);
      begin
        repeat (1000) @(posedge CLK);
        n_total++;
        $display("FAIL watchdog: got timeout expected completion");
      end
    join_any
    @(posedge CLK);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL leftover: got %0d pending expected 0", sb.size());
    end
    if (n_total < 12) begin
      n_total++;
      $display("FAIL count: got %0d checks expected at least 12", n_total - 1);
    end
    if (n_pass == n_total) $display("PASS");
    else $display("FAIL summary: got %0d passed expected %0d", n_pass, n_total);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
